// File: rtl/audio_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_stream_fifo
// Description : Single-clock first-word-fall-through sample FIFO for the
//               audio output path. Holds back the DAC side until a prefill
//               level is reached, reports fill level and watermarks, supports
//               synchronous flush and counts DAC starvation (underrun) events.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_stream_fifo #(
    parameter int DATA_WIDTH    = 28,
    parameter int DEPTH         = 2048,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int PREFILL       = DEPTH / 2,
    parameter int AFULL_THRESH  = DEPTH - 16,
    parameter int AEMPTY_THRESH = 16,
    parameter int UCNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  streaming,
    output logic [UCNT_WIDTH-1:0] underrun_cnt
);

    localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_prefill = (ADDR_WIDTH+1)'(PREFILL);
    localparam logic [ADDR_WIDTH:0]   c_afull   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   c_aempty  = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_lvl_one = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [UCNT_WIDTH-1:0] c_cnt_one = {{(UCNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_PRIME  = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [UCNT_WIDTH-1:0] r_ucnt;
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic                  r_byp_sel;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_underrun;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Handshake qualifiers; flush overrides both sides of the FIFO.
    assign src_ready  = rst_n && !flush && (r_level != c_depth);
    assign streaming  = (r_state == S_STREAM);
    assign valid      = streaming && (r_level != '0);
    assign w_wr       = src_valid && src_ready;
    assign w_rd       = ready && valid && !flush;
    assign w_underrun = streaming && (r_level == '0) && ready && !flush;

    // Address of the word that will be at the head after this edge.
    assign w_rd_addr  = w_rd ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

    assign level        = r_level;
    assign almost_full  = (r_level >= c_afull);
    assign almost_empty = (r_level <= c_aempty);
    assign underrun_cnt = r_ucnt;

    // Head word comes from the bypass register when it was written in the
    // same edge the RAM was read, otherwise from the RAM read register.
    assign data = r_byp_sel ? r_byp_data : r_ram_q;

    // Next-state logic: prime until enough samples, re-prime on starvation.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PRIME:  if (r_level >= c_prefill) w_state_next = S_STREAM;
            S_STREAM: if (w_underrun)           w_state_next = S_PRIME;
            default:                            w_state_next = S_PRIME;
        endcase
        if (flush) begin
            w_state_next = S_PRIME;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointer and level bookkeeping; flush and reset empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_rd_ptr <= w_rd_addr;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating underrun counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ucnt <= '0;
        end else if (w_underrun && (r_ucnt != '1)) begin
            r_ucnt <= r_ucnt + c_cnt_one;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= src_data;
        end
    end

    // Registered RAM read of the upcoming head word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ram_q <= '0;
        end else begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    // Bypass capture: the RAM read above sees old contents when the head
    // slot is being written at this same edge (write into an empty FIFO).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_sel <= w_wr && (r_wr_ptr == w_rd_addr);
            if (w_wr) begin
                r_byp_data <= src_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_stream_fifo
// Description : Scoreboard bench for audio_stream_fifo (DEPTH=16, PREFILL=8,
//               AFULL_THRESH=12, AEMPTY_THRESH=4, DATA_WIDTH=28).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_stream_fifo;

    localparam int DW    = 28;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int UW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;
    logic          streaming;
    logic [UW-1:0] underrun_cnt;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;

    audio_stream_fifo #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .ADDR_WIDTH    (AW),
        .PREFILL       (8),
        .AFULL_THRESH  (12),
        .AEMPTY_THRESH (4),
        .UCNT_WIDTH    (UW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .ready        (ready),
        .valid        (valid),
        .data         (data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .streaming    (streaming),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; acc is whether the write must be accepted.
    task automatic drive(input logic sv, input logic [DW-1:0] d, input logic rdy,
                         input logic fl, input logic acc);
        src_valid = sv;
        src_data  = d;
        ready     = rdy;
        flush     = fl;
        #1;
        if (sv) begin
            chk("src_ready", src_ready, acc);
            if (acc) exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed read is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !flush && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_data: got %0d, expected no word (t=%0t)", data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", data, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; src_valid = 1'b0; src_data = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_valid", valid, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_streaming", streaming, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;

        // Prefill gate
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
            chk("prime_valid", valid, 0);
        end
        chk("prime_level7", level, 7);
        drive(1'b1, DW'(8), 1'b1, 1'b0, 1'b1);
        chk("prime_level8", level, 8);
        chk("prime_valid_at8", valid, 0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream_valid", valid, 1);
        chk("stream_streaming", streaming, 1);
        chk("stream_data1", data, 1);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_level", level, 0);
        chk("drain_streaming", streaming, 1);

        // Full and watermarks (first write into empty streaming FIFO uses bypass)
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, DW'(100 + k), 1'b0, 1'b0, 1'b1);
            chk("fill_level", level, k);
            chk("fill_afull", almost_full, (k >= 12));
            chk("fill_aempty", almost_empty, (k <= 4));
            if (k == 1) begin
                chk("bypass_valid", valid, 1);
                chk("bypass_data", data, 101);
                chk("idle_no_underrun", underrun_cnt, 0);
            end
        end
        chk("full_src_ready", src_ready, 0);
        drive(1'b1, DW'(200), 1'b1, 1'b0, 1'b0);
        chk("full_read_level", level, 15);
        for (int i = 0; i < 15; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("full_drain_level", level, 0);
        chk("full_drain_sb_empty", exp_q.size(), 0);

        // Underrun
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("urun_cnt", underrun_cnt, 1);
        chk("urun_streaming", streaming, 0);
        chk("urun_valid", valid, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(300 + i), 1'b1, 1'b0, 1'b1);
            chk("reprime_valid", valid, 0);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("restream_valid", valid, 1);
        chk("restream_data", data, 301);

        // Concurrent read/write across pointer wrap
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1, DW'(400 + i), 1'b1, 1'b0, 1'b1);
            chk("conc_level", level, 8);
        end
        drive(1'b1, DW'(441), 1'b0, 1'b0, 1'b1);
        drive(1'b1, DW'(442), 1'b0, 1'b0, 1'b1);
        chk("preflush_level", level, 10);
        chk("preflush_streaming", streaming, 1);

        // Flush
        drive(1'b1, DW'(500), 1'b1, 1'b1, 1'b0);
        exp_q.delete();
        chk("flush_level", level, 0);
        chk("flush_valid", valid, 0);
        chk("flush_streaming", streaming, 0);
        chk("flush_ucnt", underrun_cnt, 1);
        for (int i = 1; i <= 9; i++) drive(1'b1, DW'(600 + i), 1'b0, 1'b0, 1'b1);
        chk("postflush_level", level, 9);
        chk("postflush_valid", valid, 1);
        chk("postflush_data", data, 601);

        // Reset mid-stream
        rst_n = 1'b0; src_valid = 1'b1; src_data = DW'(700); ready = 1'b1; flush = 1'b0;
        #1;
        chk("inrst_src_ready", src_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; src_valid = 1'b0; ready = 1'b0;
        exp_q.delete();
        #1;
        chk("mrst_level", level, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_ucnt", underrun_cnt, 0);
        chk("mrst_aempty", almost_empty, 1);
        chk("mrst_streaming", streaming, 0);
        chk("mrst_src_ready", src_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
